// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and helpers for the byte-wide RAM arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_e;

  localparam logic [1:0]  LEN_BYTE  = 2'd0;
  localparam logic [1:0]  LEN_HALF  = 2'd1;
  localparam logic [1:0]  LEN_WORD  = 2'd2;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        RstEnable = 1'b1;

  // Both length codes 2 and 3 denote a full word.
  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_byte_assembler.sv
// Little-endian word builder: inserts one byte at a given lane each cycle, clearable.
module mem_arbiter_byte_assembler
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [1:0]  idx_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] next_o
);

  logic [31:0] word_q, word_d;

  // next_o exposes the word including this cycle's byte so the final byte
  // can be returned in the same edge that completes the transfer.
  always_comb begin
    next_o = word_q;
    if (en_i) next_o[{idx_i, 3'b000} +: 8] = byte_i;
    word_d = clr_i ? ZeroWord : next_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) word_q <= ZeroWord;
    else                  word_q <= word_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and the MEM stage.
// Optional build macro MEMARB_PREEMPT_EN lets a MEM request abort an early fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_wr_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              mem_busy,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              ram_wr
);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d, cnt_nxt;
  logic [2:0]        n_q, n_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              asm_clr, asm_en, preempt;
  logic [1:0]        asm_idx;
  logic [31:0]       asm_next;

`ifdef MEMARB_PREEMPT_EN
  // Once the fourth byte address is on the bus the fetch is allowed to finish.
  assign preempt = mem_req && (cnt_q < 3'd3);
`else
  assign preempt = 1'b0;
`endif

  // Byte k arrives one cycle after its address, i.e. while cnt_q == k+1.
  assign asm_idx = cnt_q[1:0] - 2'd1;

  mem_arbiter_byte_assembler u_byte_assembler (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (asm_clr),
    .en_i   (asm_en),
    .idx_i  (asm_idx),
    .byte_i (ram_din),
    .next_o (asm_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    asm_clr     = 1'b0;
    asm_en      = 1'b0;
    cnt_nxt     = cnt_q + 3'd1;

    case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        if (mem_req) begin
          base_d  = mem_addr;
          ram_a_d = mem_addr;
          n_d     = len_to_n(mem_len);
          wdata_d = mem_wdata;
          asm_clr = 1'b1;
          if (mem_wr_en) begin
            state_d    = MEM_WR;
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
          end else begin
            state_d = MEM_RD;
          end
        end else if (if_req && !if_flush) begin
          base_d  = if_addr;
          ram_a_d = if_addr;
          n_d     = 3'd4;
          asm_clr = 1'b1;
          state_d = IF_RD;
        end
      end

      IF_RD, MEM_RD: begin
        cnt_d  = cnt_nxt;
        asm_en = (cnt_q != 3'd0);
        if (cnt_nxt < n_q) ram_a_d = base_q + ADDR_W'(cnt_nxt);
        if (cnt_q == n_q) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          if (state_q == IF_RD) begin
            if_done_d = 1'b1;
            if_inst_d = asm_next;
          end else begin
            mem_done_d  = 1'b1;
            mem_rdata_d = asm_next;
          end
        end
        // Aborted fetches leave no trace in the returned instruction word.
        if (state_q == IF_RD && (if_flush || preempt)) begin
          state_d   = IDLE;
          cnt_d     = 3'd0;
          ram_a_d   = ram_a_q;
          if_done_d = 1'b0;
          if_inst_d = if_inst_q;
          asm_en    = 1'b0;
        end
      end

      MEM_WR: begin
        if (cnt_nxt < n_q) begin
          cnt_d      = cnt_nxt;
          ram_a_d    = base_q + ADDR_W'(cnt_nxt);
          ram_dout_d = wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
          ram_wr_d   = 1'b1;
        end else begin
          state_d    = IDLE;
          cnt_d      = 3'd0;
          mem_done_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      base_q      <= '0;
      wdata_q     <= ZeroWord;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'h00;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= ZeroWord;
      mem_rdata_q <= ZeroWord;
    end else begin
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // A flush landing on the done cycle suppresses the pulse.
  assign if_done   = if_done_q & ~if_flush;
  assign if_inst   = if_inst_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;
  assign mem_busy  = (rst != RstEnable) &&
                     (mem_req || state_q == MEM_RD || state_q == MEM_WR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency byte RAM model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_inst;
  logic        mem_req, mem_wr_en, mem_done, mem_busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_len;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'h00;
  logic        ram_wr;

  int checks = 0;
  int errors = 0;
  int id_cyc, md_cyc;

  logic [7:0]  ram [0:1023];
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [7:0]  pl_data;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_done   (if_done),
    .if_inst   (if_inst),
    .mem_req   (mem_req),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_len   (mem_len),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .mem_busy  (mem_busy),
    .ram_a     (ram_a),
    .ram_dout  (ram_dout),
    .ram_din   (ram_din),
    .ram_wr    (ram_wr)
  );

  always #5 clk = ~clk;

  // RAM: 1 KiB image, addresses wrap on the low 10 bits.
  always @(posedge clk) begin
    if (pl_en)       ram[pl_addr] <= pl_data;
    else if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
    ram_din <= ram[ram_a[9:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
    mem_req = 1'b0; mem_wr_en = 1'b0; mem_addr = 32'h0; mem_len = 2'd0; mem_wdata = 32'h0;
    pl_en = 1'b0; pl_addr = 10'h0; pl_data = 8'h0;
    tick();
    preload(10'h100, 8'h13); preload(10'h101, 8'h05); preload(10'h102, 8'h10); preload(10'h103, 8'h00);
    preload(10'h104, 8'h37); preload(10'h105, 8'h12); preload(10'h106, 8'h00); preload(10'h107, 8'h00);
    preload(10'h200, 8'h93); preload(10'h201, 8'h00); preload(10'h202, 8'h50); preload(10'h203, 8'h00);
    preload(10'h040, 8'h7F); preload(10'h3FF, 8'hA5); preload(10'h000, 8'h5A); preload(10'h031, 8'hEE);
    #1;
    chk("rst_if_done",   {31'b0, if_done},  32'd0);
    chk("rst_mem_done",  {31'b0, mem_done}, 32'd0);
    chk("rst_if_inst",   if_inst,           32'd0);
    chk("rst_mem_rdata", mem_rdata,         32'd0);
    chk("rst_ram_a",     ram_a,             32'd0);
    chk("rst_ram_wr",    {31'b0, ram_wr},   32'd0);
    chk("rst_ram_dout",  {24'b0, ram_dout}, 32'd0);
    chk("rst_mem_busy",  {31'b0, mem_busy}, 32'd0);
    rst = 1'b0;
    tick();

    // IF only, 4-byte fetch from 0x100
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 6) if_req = 1'b0;
      #1;
      chk("t1_if_done", {31'b0, if_done}, (c == 6) ? 32'd1 : 32'd0);
      if (c <= 4) chk("t1_ram_a", ram_a, 32'h100 + c - 1);
    end
    chk("t1_if_inst", if_inst, 32'h0010_0513);
    tick();

    // MEM 2-byte write to 0x20
    mem_req = 1'b1; mem_wr_en = 1'b1; mem_addr = 32'h20; mem_len = 2'd1; mem_wdata = 32'hAABB_CCDD;
    #1;
    chk("t2_busy_c0", {31'b0, mem_busy}, 32'd1);
    tick(); #1;
    chk("t2_wr_c1",   {31'b0, ram_wr}, 32'd1);
    chk("t2_a_c1",    ram_a, 32'h20);
    chk("t2_dout_c1", {24'b0, ram_dout}, 32'hDD);
    chk("t2_busy_c1", {31'b0, mem_busy}, 32'd1);
    tick(); #1;
    chk("t2_wr_c2",   {31'b0, ram_wr}, 32'd1);
    chk("t2_a_c2",    ram_a, 32'h21);
    chk("t2_dout_c2", {24'b0, ram_dout}, 32'hCC);
    chk("t2_done_c2", {31'b0, mem_done}, 32'd0);
    tick();
    mem_req = 1'b0; mem_wr_en = 1'b0;
    #1;
    chk("t2_done_c3", {31'b0, mem_done}, 32'd1);
    chk("t2_wr_c3",   {31'b0, ram_wr}, 32'd0);
    chk("t2_rdata",   mem_rdata, 32'd0);
    chk("t2_busy_c3", {31'b0, mem_busy}, 32'd0);
    tick();
    chk("t2_ram20", {24'b0, ram[10'h020]}, 32'hDD);
    chk("t2_ram21", {24'b0, ram[10'h021]}, 32'hCC);

    // Simultaneous IF (0x104) and MEM 1-byte read (0x40): MEM first
    if_req = 1'b1; if_addr = 32'h104;
    mem_req = 1'b1; mem_wr_en = 1'b0; mem_addr = 32'h40; mem_len = 2'd0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 3) mem_req = 1'b0;
      if (c == 9) if_req = 1'b0;
      #1;
      chk("t3_mem_done", {31'b0, mem_done}, (c == 3) ? 32'd1 : 32'd0);
      chk("t3_if_done",  {31'b0, if_done},  (c == 9) ? 32'd1 : 32'd0);
      if (c == 3) chk("t3_rdata", mem_rdata, 32'h0000_007F);
      if (c == 4) chk("t3_ram_a", ram_a, 32'h104);
    end
    chk("t3_if_inst", if_inst, 32'h0000_1237);
    tick();

    // Flush in cycle 3 of a fetch, then refetch from 0x200
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 3) if_flush = 1'b1;
      if (c == 4) begin if_flush = 1'b0; if_addr = 32'h200; end
      if (c == 10) if_req = 1'b0;
      #1;
      chk("t4_if_done", {31'b0, if_done}, (c == 10) ? 32'd1 : 32'd0);
      if (c == 5) chk("t4_ram_a", ram_a, 32'h200);
    end
    chk("t4_if_inst", if_inst, 32'h0050_0093);
    tick();

    // Flush coincident with the done cycle; the request under flush is ignored
    if_req = 1'b1; if_addr = 32'h104;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 6) begin if_flush = 1'b1; if_addr = 32'h200; end
      #1;
      chk("t4b_if_done", {31'b0, if_done}, 32'd0);
    end
    tick();
    if_flush = 1'b0; if_req = 1'b0;
    #1;
    chk("t4b_ram_a_hold", ram_a, 32'h107);
    tick();

    // Reset in cycle 2 of a 4-byte MEM write
    mem_req = 1'b1; mem_wr_en = 1'b1; mem_addr = 32'h30; mem_len = 2'd2; mem_wdata = 32'h1122_3344;
    tick(); #1;
    chk("t5_wr_c1",   {31'b0, ram_wr}, 32'd1);
    chk("t5_dout_c1", {24'b0, ram_dout}, 32'h44);
    tick();
    rst = 1'b1;
    #1;
    chk("t5_rst_wr",    {31'b0, ram_wr},   32'd0);
    chk("t5_rst_a",     ram_a,             32'd0);
    chk("t5_rst_dout",  {24'b0, ram_dout}, 32'd0);
    chk("t5_rst_busy",  {31'b0, mem_busy}, 32'd0);
    chk("t5_rst_inst",  if_inst,           32'd0);
    chk("t5_rst_rdata", mem_rdata,         32'd0);
    mem_req = 1'b0; mem_wr_en = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_no_done", {31'b0, mem_done}, 32'd0);
    end
    chk("t5_ram30", {24'b0, ram[10'h030]}, 32'h44);
    chk("t5_ram31", {24'b0, ram[10'h031]}, 32'hEE);

    // 2-byte read across the address wrap
    mem_req = 1'b1; mem_wr_en = 1'b0; mem_addr = 32'hFFFF_FFFF; mem_len = 2'd1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) mem_req = 1'b0;
      #1;
      chk("t5_wrap_done", {31'b0, mem_done}, (c == 4) ? 32'd1 : 32'd0);
      if (c == 1) chk("t5_wrap_a1", ram_a, 32'hFFFF_FFFF);
      if (c == 2) chk("t5_wrap_a2", ram_a, 32'h0);
    end
    chk("t5_wrap_rdata", mem_rdata, 32'h0000_5AA5);
    tick();

    // MEM request arriving in cycle 2 of a fetch
`ifdef MEMARB_PREEMPT_EN
    id_cyc = 12; md_cyc = 6;
`else
    id_cyc = 6;  md_cyc = 9;
`endif
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 2) begin
        mem_req = 1'b1; mem_wr_en = 1'b0; mem_addr = 32'h40; mem_len = 2'd0;
      end
      if (c == md_cyc) mem_req = 1'b0;
      if (c == id_cyc) if_req = 1'b0;
      #1;
      chk("t6_if_done",  {31'b0, if_done},  (c == id_cyc) ? 32'd1 : 32'd0);
      chk("t6_mem_done", {31'b0, mem_done}, (c == md_cyc) ? 32'd1 : 32'd0);
      if (c == 2) chk("t6_busy", {31'b0, mem_busy}, 32'd1);
    end
    chk("t6_if_inst", if_inst, 32'h0010_0513);
    chk("t6_rdata", mem_rdata, 32'h0000_007F);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
